pipeline_ctrl_sequencer: RTL and testbench

//   Central stall/flush sequencer for the 5-stage RV32 pipeline.

---
 rtl/pipeline_ctrl_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pipeline_ctrl_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_sequencer.sv
// rtl/pipeline_ctrl_sequencer.sv - stall/flush sequencer for the 5-stage RV32 pipeline
//
// Merges three requests into per-stage write-enable and flush controls:
//   - load-use stalls from the hazard detection unit
//   - taken-branch redirects resolved in EX
//   - multi-cycle data-memory busy
// Request priority is mem_busy, then branch, then load-use stall.
//
// Parameters:
//   FLUSH_CYCLES  IF/ID + ID/EX flush cycles per taken branch (1..4)
//   TIMEOUT       consecutive mem_busy cycles before timeout_err sets (1..65535)
//   CNT_W         performance counter width
//
// Build option:
//   PIPE_PERF_CNT_EN  When defined, stall_cycles and flush_count are saturating
//                     counters. When undefined, both ports are tied to 0.
//
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   load_use_stall  stall request
//   branch_taken    taken branch/jump resolved in EX
//   mem_busy        MEM-stage access not complete
//   pc_write, if_id_write, id_ex_write, ex_mem_write   register write enables
//   if_id_flush, id_ex_flush, mem_wb_flush             bubble/NOP inserts
//   seq_state       00 RUN, 01 FLUSH, 10 MEM_WAIT
//   timeout_err     sticky mem_busy timeout flag
//   stall_cycles    cycles with pc_write=0
//   flush_count     taken-branch flush events

module pipeline_ctrl_sequencer #(
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       seq_state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_FLUSH    = 2'b01,
        S_MEM_WAIT = 2'b10
    } state_t;

    localparam logic [1:0]  FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TMO_MAX      = 16'(TIMEOUT);
    localparam logic [15:0] TMO_LAST     = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  flush_rem;
    logic [1:0]  flush_rem_nxt;
    logic        branch_pend;
    logic        branch_pend_nxt;
    logic [15:0] tmo_ctr;
    logic        start_branch;
    logic        cont_flush;

    // In FLUSH, only a fresh branch restarts the flush.
    // branch_pend can only be set while frozen, so it matters only after MEM_WAIT.
    always_comb begin
        start_branch = 1'b0;
        cont_flush   = 1'b0;
        if (state == S_FLUSH) begin
            start_branch = branch_taken;
            cont_flush   = !branch_taken;
        end else begin
            start_branch = branch_taken | branch_pend;
            cont_flush   = !start_branch && (flush_rem != 2'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RUN;
            flush_rem   <= 2'd0;
            branch_pend <= 1'b0;
        end else begin
            state       <= state_nxt;
            flush_rem   <= flush_rem_nxt;
            branch_pend <= branch_pend_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        flush_rem_nxt   = flush_rem;
        branch_pend_nxt = branch_pend;
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        id_ex_write     = 1'b1;
        ex_mem_write    = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        mem_wb_flush    = 1'b0;

        if (rst) begin
            // Controls follow rst combinationally so the pipeline is quiesced
            // for the whole reset window, not just from the next edge.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (mem_busy) begin
            // Freeze everything and bubble MEM/WB.
            // A branch arriving now is remembered, and the flush count is held.
            pc_write        = 1'b0;
            if_id_write     = 1'b0;
            id_ex_write     = 1'b0;
            ex_mem_write    = 1'b0;
            mem_wb_flush    = 1'b1;
            state_nxt       = S_MEM_WAIT;
            branch_pend_nxt = branch_pend | branch_taken;
        end else if (start_branch) begin
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            flush_rem_nxt   = FLUSH_RELOAD;
            branch_pend_nxt = 1'b0;
            state_nxt       = (FLUSH_RELOAD != 2'd0) ? S_FLUSH : S_RUN;
        end else if (cont_flush) begin
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            flush_rem_nxt = (flush_rem != 2'd0) ? flush_rem - 2'd1 : 2'd0;
            state_nxt     = (flush_rem > 2'd1) ? S_FLUSH : S_RUN;
        end else begin
            state_nxt = S_RUN;
            if (load_use_stall) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Counts consecutive busy edges and saturates at TIMEOUT.
    // The error latches on the edge that completes the TIMEOUT-th busy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_ctr     <= 16'd0;
            timeout_err <= 1'b0;
        end else if (mem_busy) begin
            if (tmo_ctr != TMO_MAX) begin
                tmo_ctr <= tmo_ctr + 16'd1;
            end
            if (tmo_ctr >= TMO_LAST) begin
                timeout_err <= 1'b1;
            end
        end else begin
            tmo_ctr <= 16'd0;
        end
    end

    assign seq_state = state;

`ifdef PIPE_PERF_CNT_EN
    logic             count_flush;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign count_flush = !rst && !mem_busy && start_branch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (count_flush && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
// tb/tb_pipeline_ctrl_sequencer.sv - self-checking bench for pipeline_ctrl_sequencer

module tb_pipeline_ctrl_sequencer;

    localparam int FC  = 2;
    localparam int TMO = 4;
    localparam int CW  = 5;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int CNT_MAX = (1 << CW) - 1;

    // Control vector order: pc, if_id, id_ex, ex_mem writes, then if_id, id_ex, mem_wb flushes.
    localparam logic [6:0] V_NORM  = 7'b1111_000;
    localparam logic [6:0] V_STALL = 7'b0011_010;
    localparam logic [6:0] V_FLUSH = 7'b1111_110;
    localparam logic [6:0] V_BUSY  = 7'b0000_001;
    localparam logic [6:0] V_RST   = 7'b0000_111;

    logic          clk;
    logic          rst;
    logic          load_use_stall;
    logic          branch_taken;
    logic          mem_busy;
    logic          pc_write;
    logic          if_id_write;
    logic          id_ex_write;
    logic          ex_mem_write;
    logic          if_id_flush;
    logic          id_ex_flush;
    logic          mem_wb_flush;
    logic [1:0]    seq_state;
    logic          timeout_err;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_count;
    logic [6:0]    ctrl;

    assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                   if_id_flush, id_ex_flush, mem_wb_flush};

    pipeline_ctrl_sequencer #(
        .FLUSH_CYCLES (FC),
        .TIMEOUT      (TMO),
        .CNT_W        (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_use_stall (load_use_stall),
        .branch_taken   (branch_taken),
        .mem_busy       (mem_busy),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_write    (id_ex_write),
        .ex_mem_write   (ex_mem_write),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .mem_wb_flush   (mem_wb_flush),
        .seq_state      (seq_state),
        .timeout_err    (timeout_err),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: obligations and history rather than a state machine.
    int m_flush_left;
    bit m_pend;
    int m_busy_run;
    bit m_err;
    bit m_last_busy;
    int m_stall;
    int m_fcount;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flush_left = 0;
        m_pend       = 1'b0;
        m_busy_run   = 0;
        m_err        = 1'b0;
        m_last_busy  = 1'b0;
        m_stall      = 0;
        m_fcount     = 0;
    endtask

    // Cycle classification:
    // 0 normal, 1 load-use stall, 2 new branch flush, 3 owed flush, 4 frozen.
    function automatic int decide(input bit bt, input bit lus, input bit mb);
        if (mb) return 4;
        if (bt || m_pend) return 2;
        if (m_flush_left > 0) return 3;
        if (lus) return 1;
        return 0;
    endfunction

    function automatic logic [6:0] ctrl_of(input int c);
        case (c)
            1:       return V_STALL;
            2, 3:    return V_FLUSH;
            4:       return V_BUSY;
            default: return V_NORM;
        endcase
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_last_busy) return 2'b10;
        if (m_flush_left > 0) return 2'b01;
        return 2'b00;
    endfunction

    task automatic compare_all();
        logic [6:0] ev;
        ev = rst ? V_RST : ctrl_of(decide(branch_taken, load_use_stall, mem_busy));
        check("ctrl", 32'(ctrl), 32'(ev));
        check("seq_state", 32'(seq_state), 32'(exp_state()));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
        check("stall_cycles", 32'(stall_cycles), PERF ? 32'(m_stall) : 32'd0);
        check("flush_count", 32'(flush_count), PERF ? 32'(m_fcount) : 32'd0);
    endtask

    // Advance the model across the coming rising edge.
    task automatic step();
        int c;
        c = decide(branch_taken, load_use_stall, mem_busy);
        if (c == 4) begin
            m_pend      = m_pend | branch_taken;
            m_busy_run  = (m_busy_run < TMO) ? m_busy_run + 1 : TMO;
            if (m_busy_run >= TMO) m_err = 1'b1;
            m_last_busy = 1'b1;
            if (m_stall < CNT_MAX) m_stall++;
        end else begin
            m_busy_run  = 0;
            m_last_busy = 1'b0;
            if (c == 2) begin
                if (m_fcount < CNT_MAX) m_fcount++;
                m_flush_left = FC - 1;
                m_pend       = 1'b0;
            end else if (c == 3) begin
                m_flush_left--;
            end else if (c == 1) begin
                if (m_stall < CNT_MAX) m_stall++;
            end
        end
    endtask

    task automatic apply(input bit bt, input bit lus, input bit mb);
        @(negedge clk);
        branch_taken   = bt;
        load_use_stall = lus;
        mem_busy       = mb;
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        branch_taken   = 1'b0;
        load_use_stall = 1'b0;
        mem_busy       = 1'b0;
        rst            = 1'b1;
        model_reset();
        #1;
        check("rst_ctrl", 32'(ctrl), 32'(V_RST));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit pmb;
        rst            = 1'b1;
        branch_taken   = 1'b0;
        load_use_stall = 1'b0;
        mem_busy       = 1'b0;
        model_reset();
        #1;
        check("init_ctrl", 32'(ctrl), 32'(V_RST));
        check("init_state", 32'(seq_state), 32'd0);
        check("init_err", 32'(timeout_err), 32'd0);
        check("init_stall", 32'(stall_cycles), 32'd0);
        check("init_fcnt", 32'(flush_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset asserted mid-cycle during a memory freeze.
        apply(1'b0, 1'b0, 1'b1);
        step();
        apply(1'b0, 1'b0, 1'b1);
        check("t1_busy", 32'(ctrl), 32'(V_BUSY));
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("t1_rst_ctrl", 32'(ctrl), 32'(V_RST));
        check("t1_rst_state", 32'(seq_state), 32'd0);
        @(posedge clk);
        #1;
        compare_all();
        mem_busy = 1'b0;
        rst      = 1'b0;
        apply(1'b0, 1'b0, 1'b0);
        check("t1_run", 32'(ctrl), 32'(V_NORM));
        step();

        // Single-cycle load-use stall.
        do_reset();
        apply(1'b0, 1'b1, 1'b0);
        check("t2_stall", 32'(ctrl), 32'(V_STALL));
        step();
        apply(1'b0, 1'b0, 1'b0);
        check("t2_after", 32'(ctrl), 32'(V_NORM));
        check("t2_scnt", 32'(stall_cycles), PERF ? 32'd1 : 32'd0);
        step();

        // Branch with a two-cycle flush.
        do_reset();
        apply(1'b1, 1'b0, 1'b0);
        check("t3_f1", 32'(ctrl), 32'(V_FLUSH));
        step();
        apply(1'b0, 1'b0, 1'b0);
        check("t3_f2", 32'(ctrl), 32'(V_FLUSH));
        check("t3_st", 32'(seq_state), 32'd1);
        step();
        apply(1'b0, 1'b0, 1'b0);
        check("t3_done", 32'(ctrl), 32'(V_NORM));
        check("t3_st0", 32'(seq_state), 32'd0);
        check("t3_fcnt", 32'(flush_count), PERF ? 32'd1 : 32'd0);
        step();

        // Branch arrives during a memory freeze and is deferred.
        do_reset();
        apply(1'b0, 1'b0, 1'b1);
        step();
        apply(1'b1, 1'b0, 1'b1);
        check("t4_b2", 32'(ctrl), 32'(V_BUSY));
        step();
        apply(1'b0, 1'b0, 1'b1);
        check("t4_b3", 32'(ctrl), 32'(V_BUSY));
        step();
        apply(1'b0, 1'b0, 1'b0);
        check("t4_f1", 32'(ctrl), 32'(V_FLUSH));
        check("t4_mw", 32'(seq_state), 32'd2);
        step();
        apply(1'b0, 1'b0, 1'b0);
        check("t4_f2", 32'(ctrl), 32'(V_FLUSH));
        check("t4_fl", 32'(seq_state), 32'd1);
        check("t4_fcnt", 32'(flush_count), PERF ? 32'd1 : 32'd0);
        step();

        // Branch and load-use stall in the same cycle.
        do_reset();
        apply(1'b1, 1'b1, 1'b0);
        check("t5_ctrl", 32'(ctrl), 32'(V_FLUSH));
        step();
        apply(1'b0, 1'b0, 1'b0);
        check("t5_scnt", 32'(stall_cycles), 32'd0);
        step();

        // Timeout after four consecutive busy cycles.
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            apply(1'b0, 1'b0, 1'b1);
            check("t6_err", 32'(timeout_err), (i >= 5) ? 32'd1 : 32'd0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b0);
            check("t6_sticky", 32'(timeout_err), 32'd1);
            step();
        end

        // Randomized traffic, including occasional asynchronous resets.
        do_reset();
        pmb = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit bt;
            bit lus;
            bit mb;
            bt  = ($urandom_range(0, 99) < 15);
            lus = ($urandom_range(0, 99) < 25);
            mb  = ($urandom_range(0, 99) < (pmb ? 75 : 20));
            pmb = mb;
            apply(bt, lus, mb);
            if ($urandom_range(0, 149) == 0) begin
                #1;
                rst = 1'b1;
                model_reset();
                #1;
                compare_all();
                @(posedge clk);
                #1;
                compare_all();
                branch_taken   = 1'b0;
                load_use_stall = 1'b0;
                mem_busy       = 1'b0;
                rst            = 1'b0;
                pmb            = 1'b0;
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
